// File: rtl/spi_arb_if.sv
// Client/engine bundle for the SPI arbiter: client request/response lanes plus
// the launch/complete handshake with the shared SPI engine.
interface spi_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      spi_start;
  logic [DATA_W-1:0]         spi_send_data;
  logic                      spi_abort;
  logic                      spi_done;
  logic [DATA_W-1:0]         spi_recv_data;

  modport master (
    input  req, req_data, spi_done, spi_recv_data,
    output grant, rsp_valid, rsp_data, rsp_err, spi_start, spi_send_data, spi_abort
  );
  modport slave (
    output req, req_data, spi_done, spi_recv_data,
    input  grant, rsp_valid, rsp_data, rsp_err, spi_start, spi_send_data, spi_abort
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin owner selection for one shared SPI engine; launches a transfer,
// waits for completion or timeout, and returns the result to the owner.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic      clk,
  input  logic      rst,
  spi_arb_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;
  logic               r_spi_start, w_spi_start_nxt;
  logic [DATA_W-1:0]  r_send_data, w_send_data_nxt;
  logic               r_spi_abort, w_spi_abort_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_win, w_win_nxt;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_spi_start_nxt = 1'b0;
    w_send_data_nxt = r_send_data;
    w_spi_abort_nxt = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    w_win_nxt       = r_win;
    w_found         = 1'b0;
    w_pick          = '0;

    // Search starts just after the last winner so every requester gets a turn.
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_win_nxt           = w_pick;
          w_send_data_nxt     = bus.req_data[w_pick*DATA_W +: DATA_W];
          w_spi_start_nxt     = 1'b1;
          w_cnt_nxt           = '0;
          w_state_nxt         = LAUNCH;
        end
      end
      LAUNCH: begin
        // The launch cycle counts toward the timeout so the abort lands
        // exactly TIMEOUT cycles after the start pulse.
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.spi_done) begin
          w_rsp_data_nxt         = bus.spi_recv_data;
          w_rsp_err_nxt          = 1'b0;
          w_rsp_valid_nxt[r_win] = 1'b1;
          w_state_nxt            = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
          w_rsp_data_nxt         = '0;
          w_rsp_err_nxt          = 1'b1;
          w_spi_abort_nxt        = 1'b1;
          w_rsp_valid_nxt[r_win] = 1'b1;
          w_state_nxt            = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_grant_nxt = '0;
        w_ptr_nxt   = r_win;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_spi_start <= 1'b0;
      r_send_data <= '0;
      r_spi_abort <= 1'b0;
      r_cnt       <= '0;
      r_ptr       <= IDX_W'(NUM_REQ-1);
      r_win       <= '0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_spi_start <= w_spi_start_nxt;
      r_send_data <= w_send_data_nxt;
      r_spi_abort <= w_spi_abort_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_win       <= w_win_nxt;
    end
  end

  assign bus.grant         = r_grant;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.spi_start     = r_spi_start;
  assign bus.spi_send_data = r_send_data;
  assign bus.spi_abort     = r_spi_abort;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench: stimulus queues expected launches/responses, monitors pop
// and compare whenever the arbiter presents spi_start or rsp_valid.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct {
    logic [NR-1:0] g;
    logic [DW-1:0] d;
    int            gap;
  } launch_t;

  typedef struct {
    logic [NR-1:0] v;
    logic [DW-1:0] d;
    logic          e;
    int            lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  spi_master_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  launch_t exp_l[$];
  rsp_t    exp_r[$];
  int total = 0, bad = 0;
  int cyc = 0, n_start = 0, n_rsp = 0;
  int last_start_cyc = 0, last_rsp_cyc = 0;
  int eng_lat = 0;
  logic [DW-1:0] eng_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cyc %0d)", nm, cyc);
  endtask

  // Engine model: completion strobe is sampled eng_lat edges after the start edge.
  initial begin
    bus.spi_done      = 1'b0;
    bus.spi_recv_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.spi_start === 1'b1 && eng_lat != 0) begin
        repeat (eng_lat - 1) @(posedge clk);
        @(negedge clk);
        bus.spi_done      = 1'b1;
        bus.spi_recv_data = eng_rx;
        @(negedge clk);
        bus.spi_done      = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.spi_start === 1'b1) begin
      n_start++;
      if (exp_l.size() == 0) fail("launch");
      else begin
        launch_t l;
        l = exp_l.pop_front();
        chk("launch_grant", 32'(bus.grant), 32'(l.g));
        chk("launch_data", 32'(bus.spi_send_data), 32'(l.d));
        if (l.gap > 0) chk("launch_gap", cyc - last_rsp_cyc, l.gap);
      end
      last_start_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid !== '0) begin
      n_rsp++;
      if (exp_r.size() == 0) fail("rsp");
      else begin
        rsp_t r;
        r = exp_r.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(r.v));
        chk("rsp_data", 32'(bus.rsp_data), 32'(r.d));
        chk("rsp_err", 32'(bus.rsp_err), 32'(r.e));
        chk("rsp_abort", 32'(bus.spi_abort), 32'(r.e));
        chk("rsp_grant", 32'(bus.grant), 32'(r.v));
        chk("rsp_latency", cyc - last_start_cyc, r.lat);
      end
      last_rsp_cyc = cyc;
    end
  end

  task automatic wait_rsp(input int target, input string nm);
    int i = 0;
    while (n_rsp < target && i < 100) begin
      @(posedge clk);
      i++;
    end
    if (n_rsp < target) fail({nm, "_timeout"});
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic push_l(input logic [NR-1:0] g, input logic [DW-1:0] d, input int gap);
    launch_t l;
    l.g = g; l.d = d; l.gap = gap;
    exp_l.push_back(l);
  endtask

  task automatic push_r(input logic [NR-1:0] v, input logic [DW-1:0] d, input logic e, input int lat);
    rsp_t r;
    r.v = v; r.d = d; r.e = e; r.lat = lat;
    exp_r.push_back(r);
  endtask

  initial begin
    int nr;
    int i;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_start", 32'(bus.spi_start), 0);
    chk("rst_send", 32'(bus.spi_send_data), 0);
    chk("rst_abort", 32'(bus.spi_abort), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nr = 0;

    // Round-robin with all four requesting
    eng_lat = 4; eng_rx = 8'hA0;
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
    push_l(4'b0001, 8'h11, 0); push_l(4'b0010, 8'h22, 2); push_l(4'b0100, 8'h33, 2);
    push_l(4'b1000, 8'h44, 2); push_l(4'b0001, 8'h11, 2);
    for (int k = 0; k < 5; k++) push_r(4'b0001 << (k % 4), 8'hA0, 1'b0, 4);
    bus.req = 4'b1111;
    nr += 5; wait_rsp(nr, "rr");
    bus.req = '0;

    // Single request, late req_data change ignored
    eng_lat = 6; eng_rx = 8'h83;
    set_data(0, 8'hE2);
    push_l(4'b0001, 8'hE2, 0); push_r(4'b0001, 8'h83, 1'b0, 6);
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    set_data(0, 8'h00);
    nr += 1; wait_rsp(nr, "single");
    bus.req = '0;
    chk("single_grant_clear", 32'(bus.grant), 0);

    // Client 2 alone, then 0 and 1 together: 0 wins, then 1
    eng_lat = 3; eng_rx = 8'h5A; set_data(2, 8'hA5);
    push_l(4'b0100, 8'hA5, 0); push_r(4'b0100, 8'h5A, 1'b0, 3);
    bus.req = 4'b0100;
    nr += 1; wait_rsp(nr, "c2");
    eng_lat = 2; eng_rx = 8'h0C; set_data(0, 8'hC0); set_data(1, 8'hC1);
    push_l(4'b0001, 8'hC0, 0); push_r(4'b0001, 8'h0C, 1'b0, 2);
    bus.req = 4'b0011;
    nr += 1; wait_rsp(nr, "wrap0");
    eng_rx = 8'h1C;
    push_l(4'b0010, 8'hC1, 2); push_r(4'b0010, 8'h1C, 1'b0, 2);
    bus.req = 4'b0010;
    nr += 1; wait_rsp(nr, "wrap1");
    bus.req = '0;

    // Timeout: engine silent
    eng_lat = 0; bus.spi_recv_data = 8'hFF; set_data(3, 8'h5A);
    push_l(4'b1000, 8'h5A, 0); push_r(4'b1000, 8'h00, 1'b1, 8);
    bus.req = 4'b1000;
    nr += 1; wait_rsp(nr, "tmo");
    bus.req = '0;
    eng_lat = 5; eng_rx = 8'hC5; set_data(0, 8'h3C);
    push_l(4'b0001, 8'h3C, 0); push_r(4'b0001, 8'hC5, 1'b0, 5);
    bus.req = 4'b0001;
    nr += 1; wait_rsp(nr, "post_tmo");
    bus.req = '0;

    // Done coincides with the timeout cycle: done wins
    eng_lat = 8; eng_rx = 8'h99; set_data(1, 8'h77);
    push_l(4'b0010, 8'h77, 0); push_r(4'b0010, 8'h99, 1'b0, 8);
    bus.req = 4'b0010;
    nr += 1; wait_rsp(nr, "collide");
    bus.req = '0;

    // Reset mid-WAIT
    eng_lat = 0; set_data(2, 8'h42);
    push_l(4'b0100, 8'h42, 0);
    i = n_start;
    bus.req = 4'b0100;
    for (int k = 0; k < 50 && n_start == i; k++) @(negedge clk);
    chk("rstw_started", n_start, i + 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw_grant", 32'(bus.grant), 0);
    chk("rstw_start", 32'(bus.spi_start), 0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstw_no_rsp", n_rsp, nr);
    // Pointer back at NUM_REQ-1, so client 1 beats client 2
    eng_lat = 3; eng_rx = 8'h96; set_data(1, 8'h66);
    push_l(4'b0010, 8'h66, 0); push_r(4'b0010, 8'h96, 1'b0, 3);
    bus.req = 4'b0110;
    nr += 1; wait_rsp(nr, "rstw_c1");
    eng_rx = 8'h24;
    push_l(4'b0100, 8'h42, 2); push_r(4'b0100, 8'h24, 1'b0, 3);
    bus.req = 4'b0100;
    nr += 1; wait_rsp(nr, "rstw_c2");
    bus.req = '0;

    repeat (5) @(negedge clk);
    chk("left_launch", exp_l.size(), 0);
    chk("left_rsp", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end
endmodule
